// File: rtl/egress_drain.sv
// ---------------------------------------------------------------------------
// egress_drain
//   Self-timed drain engine for the four egress FIFOs (fifo4..fifo7).
//   Round-robin picks a non-empty FIFO and pops one word from it. The word is
//   captured one cycle after the pop and presented on a valid/ready stream.
//   The engine also checks the word's dest field against its source port.
//
// Ports
//   clk, reset       clock / async active-low reset
//   enable           allow new reads (checked in IDLE only)
//   empty[3:0]       FIFO empty flags, bit k = port k
//   data_in0..3      FIFO read data, valid one cycle after pop
//   pop[3:0]         one-hot FIFO read enable (registered)
//   data_out/port_out/valid_out, ready_in   output stream
//   error_dest       sticky dest-vs-port mismatch flag
//   cnt_idx/cnt_out  per-port delivered word count, combinational read
// ---------------------------------------------------------------------------

// Per-port saturating delivered-word counter.
module egress_drain_cnt #(
    parameter int CONT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [CONT_W-1:0] cnt
);
    logic [CONT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CONT_W{1'b1}}))
            cnt_d = cnt_q + CONT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module egress_drain #(
    parameter int TAMANO_DATOS = 12,
    parameter int CONT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    output logic [3:0]              pop,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic [1:0]              port_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    error_dest,
    input  logic [1:0]              cnt_idx,
    output logic [CONT_W-1:0]       cnt_out
);
    typedef enum logic [1:0] {IDLE, POP, CAP, OUT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [1:0]              sel_q, sel_d;
    logic [3:0]              pop_q, pop_d;
    logic [TAMANO_DATOS-1:0] data_q, data_d;
    logic [1:0]              port_q, port_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic [TAMANO_DATOS-1:0] din [4];
    logic [1:0]              pick;
    logic [1:0]              idx;
    logic                    inc;
    logic [3:0][CONT_W-1:0]  cnt_vec;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // Round-robin pick: scan from rr_ptr downward in priority; iterating
    // from the far end lets the nearest non-empty port win the last write.
    always_comb begin
        pick = rr_ptr_q;
        idx  = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (!empty[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        pop_d    = '0;          // pop is a single-cycle pulse in POP only
        data_d   = data_q;
        port_d   = port_q;
        valid_d  = valid_q;
        err_d    = err_q;
        inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (empty != 4'b1111)) begin
                    sel_d   = pick;
                    pop_d   = 4'b0001 << pick;
                    state_d = POP;
                end
            end
            POP: state_d = CAP;
            CAP: begin
                data_d  = din[sel_q];
                port_d  = sel_q;
                valid_d = 1'b1;
                if (din[sel_q][9:8] != sel_q) err_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (ready_in) begin
                    valid_d  = 1'b0;
                    inc      = 1'b1;
                    rr_ptr_d = sel_q + 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            pop_q    <= '0;
            data_q   <= '0;
            port_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            pop_q    <= pop_d;
            data_q   <= data_d;
            port_q   <= port_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_cnt
            egress_drain_cnt #(.CONT_W(CONT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc && (sel_q == 2'(k))),
                .cnt   (cnt_vec[k])
            );
        end
    endgenerate

    assign pop        = pop_q;
    assign data_out   = data_q;
    assign port_out   = port_q;
    assign valid_out  = valid_q;
    assign error_dest = err_q;
    assign cnt_out    = cnt_vec[cnt_idx];
endmodule

// File: tb/tb_egress_drain.sv
// ---------------------------------------------------------------------------
// tb_egress_drain
//   Self-checking bench for egress_drain. Four FIFOs with one-cycle read
//   latency are emulated with queues; a transaction-level model predicts
//   the order of delivered words, per-port counts and the sticky dest error.
// ---------------------------------------------------------------------------
module tb_egress_drain;
    localparam int W  = 12;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic         clr;
        logic [1:0]   port;
        logic [W-1:0] w;
    } req_t;

    logic          clk = 1'b0;
    logic          reset, enable, ready_in;
    logic [3:0]    empty = 4'hF;
    logic [W-1:0]  din [4] = '{default: '0};
    logic [1:0]    cnt_idx;
    logic [3:0]    pop;
    logic [W-1:0]  data_out;
    logic [1:0]    port_out;
    logic          valid_out, error_dest;
    logic [CW-1:0] cnt_out;

    egress_drain #(.TAMANO_DATOS(W), .CONT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .pop(pop), .data_out(data_out), .port_out(port_out), .valid_out(valid_out),
        .ready_in(ready_in), .error_dest(error_dest), .cnt_idx(cnt_idx), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // FIFO emulation: pops use pre-edge queue state, then pending loads apply.
    logic [W-1:0] fq [4][$];
    req_t         pend [$];
    int           pend_rd = 0;
    int           pop_viol = 0, pop_seen = 0;

    always @(posedge clk) begin : fifo_emu
        int rd;
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            if (pop[k]) begin
                if (fq[k].size() == 0) pop_viol <= pop_viol + 1;
                else din[k] <= fq[k].pop_front();
            end
        end
        if (pop != 4'b0) pop_seen <= pop_seen + 1;
        if (pop != 4'b0 && !$onehot(pop)) pop_viol <= pop_viol + 1;
        rd = pend_rd;
        while (rd < pend.size()) begin
            if (pend[rd].clr) for (int k = 0; k < 4; k++) fq[k].delete();
            else fq[pend[rd].port].push_back(pend[rd].w);
            rd++;
        end
        pend_rd <= rd;
        for (int k = 0; k < 4; k++) e[k] = (fq[k].size() == 0);
        empty <= e;
    end

    // Output stream monitor: records every accepted word.
    logic [W-1:0] obs_w [$];
    logic [1:0]   obs_p [$];
    always @(negedge clk) begin
        if (reset === 1'b1 && valid_out === 1'b1 && ready_in === 1'b1) begin
            obs_w.push_back(data_out);
            obs_p.push_back(port_out);
        end
    end

    // Transaction-level reference model.
    logic [W-1:0] mq [4][$];
    int           mrr;
    int           mcnt [4];
    bit           merr;

    function automatic int next_port();
        for (int i = 0; i < 4; i++)
            if (mq[(mrr + i) % 4].size() > 0) return (mrr + i) % 4;
        return -1;
    endfunction

    task automatic predict(output logic [W-1:0] w, output logic [1:0] p);
        int k;
        k = next_port();
        if (k < 0) begin w = '0; p = '0; return; end
        p = 2'(k);
        w = mq[k].pop_front();
        mrr = (k + 1) % 4;
        if (mcnt[k] < CMAX) mcnt[k]++;
        if (w[9:8] != p) merr = 1'b1;
    endtask

    task automatic load(input int k, input logic [W-1:0] w);
        req_t r;
        r.clr = 1'b0; r.port = 2'(k); r.w = w;
        pend.push_back(r);
        mq[k].push_back(w);
    endtask

    task automatic clear_fifos();
        req_t r;
        r.clr = 1'b1; r.port = '0; r.w = '0;
        pend.push_back(r);
        for (int k = 0; k < 4; k++) mq[k].delete();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_obs(input int n, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (obs_w.size() >= n) begin ok = 1'b1; break; end
            if (rnd) ready_in = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; ready_in = 1'b0; cnt_idx = '0;
        for (int k = 0; k < 4; k++) load(k, 12'(k * 3 + 1));
        for (int c = 0; c < 6; c++) begin
            enable = 1'($urandom); ready_in = 1'($urandom); cnt_idx = 2'($urandom);
            step();
            tests++;
            if (pop !== 4'b0 || valid_out !== 1'b0 || error_dest !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: pop=%b valid=%b err=%b, want 0000/0/0", pop, valid_out, error_dest);
            end
        end
        tests++;
        if (data_out !== '0 || port_out !== '0) begin
            fails++;
            $display("FAIL reset_data: data=%h port=%0d, want 000/0", data_out, port_out);
        end
        for (int k = 0; k < 4; k++) begin
            cnt_idx = 2'(k); #1;
            tests++;
            if (cnt_out !== '0) begin
                fails++;
                $display("FAIL reset_cnt%0d: got %0d want 0", k, cnt_out);
            end
        end
        clear_fifos();
        step(); step();
        enable = 1'b1; ready_in = 1'b1;
        begin
            int s;
            s = pop_seen;
            reset = 1'b1;
            repeat (10) step();
            tests++;
            if (pop_seen != s || valid_out !== 1'b0) begin
                fails++;
                $display("FAIL idle_all_empty: pops=%0d valid=%b, want 0 pops, valid 0", pop_seen - s, valid_out);
            end
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w; logic [1:0] p; int c;
        ready_in = 1'b1; enable = 1'b1;
        load(1, 12'h1A5);
        c = 0;
        while (pop === 4'b0 && c < 20) begin step(); c++; end
        tests++;
        if (pop !== 4'b0010) begin
            fails++; $display("FAIL single_pop: got %b want 0010", pop);
        end
        step();
        tests++;
        if (pop !== 4'b0 || valid_out !== 1'b0) begin
            fails++; $display("FAIL single_cap: pop=%b valid=%b want 0000/0", pop, valid_out);
        end
        step();
        predict(w, p);
        tests++;
        if (valid_out !== 1'b1 || data_out !== w || port_out !== p) begin
            fails++;
            $display("FAIL single_out: valid=%b data=%h port=%0d want 1/%h/%0d", valid_out, data_out, port_out, w, p);
        end
        step(); step();
        cnt_idx = 2'd1; #1;
        tests++;
        if (cnt_out !== CW'(mcnt[1]) || error_dest !== merr) begin
            fails++;
            $display("FAIL single_cnt: cnt=%0d err=%b want %0d/%b", cnt_out, error_dest, mcnt[1], merr);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] w; logic [1:0] p; bit ok; int base;
        base = obs_w.size();
        ready_in = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) load(k, {2'($urandom), 2'(k), 8'($urandom)});
        wait_obs(base + 8, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rr_timeout: got %0d words want 8", obs_w.size() - base); end
        for (int i = 0; i < 8 && ok; i++) begin
            predict(w, p);
            tests++;
            if (obs_w[base + i] !== w || obs_p[base + i] !== p) begin
                fails++;
                $display("FAIL rr_word%0d: got %h/p%0d want %h/p%0d", i, obs_w[base + i], obs_p[base + i], w, p);
            end
        end
        step(); step();
        for (int k = 0; k < 4; k++) begin
            cnt_idx = 2'(k); #1;
            tests++;
            if (cnt_out !== CW'(mcnt[k])) begin
                fails++; $display("FAIL rr_cnt%0d: got %0d want %0d", k, cnt_out, mcnt[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w; logic [1:0] p; bit ok; int base, c, pre, nxt;
        base = obs_w.size();
        ready_in = 1'b0;
        load(0, 12'h055);
        load(3, 12'h3AA);
        c = 0;
        while (valid_out !== 1'b1 && c < 30) begin step(); c++; end
        pre = mcnt[next_port()];
        predict(w, p);
        cnt_idx = p;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (valid_out !== 1'b1 || data_out !== w || port_out !== p || pop !== 4'b0 || cnt_out !== CW'(pre)) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b d=%h p=%0d pop=%b cnt=%0d want 1/%h/%0d/0000/%0d",
                         i, valid_out, data_out, port_out, pop, cnt_out, w, p, pre);
            end
        end
        ready_in = 1'b1;
        step();
        tests++;
        if (valid_out !== 1'b0 || pop !== 4'b0 || cnt_out !== CW'(mcnt[p])) begin
            fails++;
            $display("FAIL bp_release: v=%b pop=%b cnt=%0d want 0/0000/%0d", valid_out, pop, cnt_out, mcnt[p]);
        end
        nxt = next_port();
        step();
        tests++;
        if (pop !== (4'b0001 << nxt)) begin
            fails++; $display("FAIL bp_next_pop: got %b want port %0d", pop, nxt);
        end
        wait_obs(base + 2, 1'b0, ok);
        predict(w, p);
        tests++;
        if (!ok || obs_w[base + 1] !== w || obs_p[base + 1] !== p) begin
            fails++; $display("FAIL bp_second: ok=%b want %h/p%0d", ok, w, p);
        end
        step(); step();
    endtask

    task automatic test_dest_mismatch();
        logic [W-1:0] w; logic [1:0] p; bit ok; int base, c;
        base = obs_w.size();
        tests++;
        if (error_dest !== 1'b0) begin fails++; $display("FAIL dest_pre: got %b want 0", error_dest); end
        load(2, 12'h0C3);
        c = 0;
        while (valid_out !== 1'b1 && c < 30) begin step(); c++; end
        predict(w, p);
        tests++;
        if (error_dest !== 1'b1 || data_out !== w) begin
            fails++; $display("FAIL dest_rise: err=%b data=%h want 1/%h", error_dest, data_out, w);
        end
        load(1, 12'h155);
        load(0, 12'h0AA);
        wait_obs(base + 3, 1'b0, ok);
        for (int i = 1; i < 3; i++) begin
            predict(w, p);
            tests++;
            if (!ok || obs_w[base + i] !== w || obs_p[base + i] !== p) begin
                fails++; $display("FAIL dest_word%0d: ok=%b want %h/p%0d", i, ok, w, p);
            end
        end
        step(); step();
        tests++;
        if (error_dest !== 1'b1) begin fails++; $display("FAIL dest_sticky: got %b want 1", error_dest); end
    endtask

    task automatic test_random();
        logic [W-1:0] w; logic [1:0] p; bit ok; int base, n, m;
        base = obs_w.size(); n = 0;
        for (int k = 0; k < 4; k++) begin
            m = $urandom_range(0, 5);
            for (int j = 0; j < m; j++)
                load(k, {2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'(k), 8'($urandom)});
            n += m;
        end
        wait_obs(base + n, 1'b1, ok);
        ready_in = 1'b1;
        tests++;
        if (!ok) begin fails++; $display("FAIL rand_timeout: got %0d want %0d", obs_w.size() - base, n); end
        for (int i = 0; i < n && ok; i++) begin
            predict(w, p);
            tests++;
            if (obs_w[base + i] !== w || obs_p[base + i] !== p) begin
                fails++;
                $display("FAIL rand_word%0d: got %h/p%0d want %h/p%0d", i, obs_w[base + i], obs_p[base + i], w, p);
            end
        end
        step(); step();
        for (int k = 0; k < 4; k++) begin
            cnt_idx = 2'(k); #1;
            tests++;
            if (cnt_out !== CW'(mcnt[k])) begin
                fails++; $display("FAIL rand_cnt%0d: got %0d want %0d", k, cnt_out, mcnt[k]);
            end
        end
        tests++;
        if (error_dest !== merr) begin fails++; $display("FAIL rand_err: got %b want %b", error_dest, merr); end
    endtask

    task automatic test_reset_mid_out();
        int c;
        ready_in = 1'b0;
        load(1, 12'h15A);
        c = 0;
        while (valid_out !== 1'b1 && c < 30) begin step(); c++; end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || pop !== 4'b0 || data_out !== '0 || error_dest !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: v=%b pop=%b d=%h err=%b want 0/0000/000/0", valid_out, pop, data_out, error_dest);
        end
        clear_fifos();
        mrr = 0; merr = 1'b0;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        step(); step();
        reset = 1'b1;
        ready_in = 1'b1;
        cnt_idx = 2'd1; #1;
        tests++;
        if (cnt_out !== '0) begin fails++; $display("FAIL reset_mid_cnt: got %0d want 0", cnt_out); end
    endtask

    task automatic test_saturation();
        logic [W-1:0] w; logic [1:0] p; bit ok; int base, bad;
        base = obs_w.size(); bad = 0;
        ready_in = 1'b1;
        for (int j = 0; j < 260; j++) load(3, {2'($urandom), 2'd3, 8'(j)});
        wait_obs(base + 260, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL sat_timeout: got %0d want 260", obs_w.size() - base); end
        for (int i = 0; i < 260 && ok; i++) begin
            predict(w, p);
            if (obs_w[base + i] !== w || obs_p[base + i] !== p) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL sat_words: %0d words differ, want 0", bad); end
        step(); step();
        cnt_idx = 2'd3; #1;
        tests++;
        if (cnt_out !== CW'(mcnt[3])) begin
            fails++; $display("FAIL sat_cnt: got %0d want %0d", cnt_out, mcnt[3]);
        end
        tests++;
        if (pop_viol != 0) begin fails++; $display("FAIL pop_protocol: %0d bad pops, want 0", pop_viol); end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; ready_in = 1'b0; cnt_idx = '0;
        mrr = 0; merr = 1'b0;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_dest_mismatch();
        test_random();
        test_reset_mid_out();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
